// File: rtl/usb_rx_ctrl_gen.sv
// usb_rx_ctrl_gen: USB bulk RX sequencer that checks SYNC/PID, classifies packets,
// bounds payload length, runs an inter-byte timeout and reports typed errors.
`timescale 1ns/1ps
module usb_rx_ctrl_gen #(
    parameter logic [7:0] SYNC_BYTE      = 8'h80,
    parameter int         MAX_PKT_BYTES  = 64,
    parameter int         TIMEOUT_CYCLES = 96,
    parameter int         CNT_W          = $clog2(MAX_PKT_BYTES + 3),
    parameter int         TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             byte_complete,
    input  logic [7:0]       rx_byte,
    input  logic             eop,
    input  logic             crc5_ok,
    input  logic             crc16_ok,
    output logic             enable_timer,
    output logic             load_data,
    output logic             crc_check_5,
    output logic             crc_check_16,
    output logic [1:0]       pkt_type,
    output logic [3:0]       pid,
    output logic [CNT_W-1:0] byte_count,
    output logic [2:0]       err_code,
    output logic             load_error,
    output logic             load_done
);
    typedef enum logic [3:0] {IDLE, SYNC, PID, TOKEN, DATA, HSHK, CRC_CHK, ERROR, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_BYTES + 2);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             eop_seen;
    logic             running, timeout, pid_ok, at_max;
    logic [CNT_W-1:0] cnt_inc;

    assign running      = state inside {SYNC, PID, TOKEN, DATA, HSHK, DRAIN};
    assign enable_timer = running;
    assign timeout      = running && timer == TMR_MAX && !byte_complete && !eop;
    assign pid_ok       = rx_byte[7:4] == ~rx_byte[3:0];
    assign at_max       = byte_count == CNT_MAX;
    // byte count including a byte strobed this cycle, so a coincident eop sees it
    assign cnt_inc      = byte_count + CNT_W'(byte_complete && !at_max);
    assign load_data    = state == DATA && byte_complete && !at_max;
    assign crc_check_5  = state == CRC_CHK && pkt_type == 2'b01;
    assign crc_check_16 = state == CRC_CHK && pkt_type == 2'b10;
    assign load_error   = state == ERROR;
    assign load_done    = state == DONE;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            pid        <= '0;
            pkt_type   <= '0;
            byte_count <= '0;
            err_code   <= '0;
            timer      <= '0;
            eop_seen   <= 1'b0;
        end else begin
            // every state change out of a running state coincides with a byte or a non-running state
            timer <= (running && !byte_complete) ? timer + TMR_W'(1) : '0;
            if (eop && state != IDLE)
                eop_seen <= 1'b1;
            case (state)
                IDLE: if (d_edge) begin
                    pid        <= '0;
                    pkt_type   <= '0;
                    err_code   <= '0;
                    byte_count <= '0;
                    eop_seen   <= 1'b0;
                    state      <= SYNC;
                end
                SYNC: begin
                    if (byte_complete && rx_byte != SYNC_BYTE) begin state <= ERROR; err_code <= 3'd1; end
                    else if (eop) begin state <= ERROR; err_code <= 3'd3; end
                    else if (byte_complete) state <= PID;
                    else if (timeout) begin state <= ERROR; err_code <= 3'd6; end
                end
                PID: begin
                    if (byte_complete && !pid_ok) begin state <= ERROR; err_code <= 3'd2; end
                    else if (eop) begin state <= ERROR; err_code <= 3'd3; end
                    else if (byte_complete) begin
                        pid <= rx_byte[3:0];
                        case (rx_byte[3:0]) inside
                            4'b0001, 4'b1001, 4'b1101, 4'b0101: begin state <= TOKEN; pkt_type <= 2'b01; end
                            4'b0011, 4'b1011:                   begin state <= DATA;  pkt_type <= 2'b10; end
                            4'b0010, 4'b1010, 4'b1110:          begin state <= HSHK;  pkt_type <= 2'b11; end
                            default:                            begin state <= ERROR; err_code <= 3'd2; end
                        endcase
                    end else if (timeout) begin state <= ERROR; err_code <= 3'd6; end
                end
                TOKEN: begin
                    byte_count <= cnt_inc;
                    if (eop) begin
                        state    <= cnt_inc == CNT_W'(2) ? CRC_CHK : ERROR;
                        err_code <= cnt_inc == CNT_W'(2) ? err_code : 3'd3;
                    end else if (timeout) begin state <= ERROR; err_code <= 3'd6; end
                end
                DATA: begin
                    if (byte_complete && at_max) begin state <= ERROR; err_code <= 3'd4; end
                    else begin
                        byte_count <= cnt_inc;
                        if (eop) begin
                            state    <= cnt_inc >= CNT_W'(2) ? CRC_CHK : ERROR;
                            err_code <= cnt_inc >= CNT_W'(2) ? err_code : 3'd3;
                        end else if (timeout) begin state <= ERROR; err_code <= 3'd6; end
                    end
                end
                HSHK: begin
                    if (byte_complete) begin state <= ERROR; err_code <= 3'd3; end
                    else if (eop) state <= DONE;
                    else if (timeout) begin state <= ERROR; err_code <= 3'd6; end
                end
                CRC_CHK: begin
                    state    <= (pkt_type == 2'b01 ? crc5_ok : crc16_ok) ? DONE : ERROR;
                    err_code <= (pkt_type == 2'b01 ? crc5_ok : crc16_ok) ? err_code : 3'd5;
                end
                ERROR:   state <= (eop_seen || eop || err_code == 3'd5 || err_code == 3'd6) ? DONE : DRAIN;
                DRAIN:   if (eop || timeout) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
